// File: rtl/sram_bus_arbiter_pkg.sv
// Shared source IDs, grant-state encoding and request bundle for the SRAM bus arbiter.
package sram_bus_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD_I = 2'd1,
        ST_HOLD_D = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/sram_bus_arbiter_src_id_fifo.sv
// In-order FIFO of 1-bit source IDs, one entry per accepted but unanswered request.
module sram_bus_arbiter_src_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like slave between the fetch (I) and load/store (D) masters and
// routes each slave response back to the master whose request it answers.
//
// state     | meaning
// ST_IDLE   | no locked master; D wins over I when the ID FIFO has room
// ST_HOLD_I | I request presented but not yet accepted; grant locked to I
// ST_HOLD_D | D request presented but not yet accepted; grant locked to D
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    output logic        err_stray
);

    arb_state_e state_q, state_d;
    logic       grant;
    logic       s_req_raw;
    logic       accept;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    bus_req_t   i_bus, d_bus, s_bus;

    assign i_bus = {i_wr, i_size, i_wstrb, i_addr, i_wdata};
    assign d_bus = {d_wr, d_size, d_wstrb, d_addr, d_wdata};

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant     = SRC_INST;
        s_req_raw = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant = d_req ? SRC_DATA : SRC_INST;
                if (!fifo_full) begin
                    s_req_raw = d_req | i_req;
                    if (s_req_raw && !s_addr_ok)
                        state_d = d_req ? ST_HOLD_D : ST_HOLD_I;
                end
            end
            ST_HOLD_I: begin
                grant     = SRC_INST;
                s_req_raw = i_req;
                if (!i_req || s_addr_ok)
                    state_d = ST_IDLE;
            end
            ST_HOLD_D: begin
                grant     = SRC_DATA;
                s_req_raw = d_req;
                if (!d_req || s_addr_ok)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are gated with reset so nothing leaks out while the slave is also held in reset.
    assign s_bus     = (grant == SRC_DATA) ? d_bus : i_bus;
    assign s_req     = s_req_raw & ~reset;
    assign s_wr      = s_bus.wr;
    assign s_size    = s_bus.size;
    assign s_wstrb   = s_bus.wstrb;
    assign s_addr    = s_bus.addr;
    assign s_wdata   = s_bus.wdata;

    assign accept    = s_req & s_addr_ok;
    assign i_addr_ok = accept & (grant == SRC_INST);
    assign d_addr_ok = accept & (grant == SRC_DATA);

    assign pop       = s_data_ok & ~fifo_empty & ~reset;
    assign i_data_ok = pop & (fifo_head == SRC_INST);
    assign d_data_ok = pop & (fifo_head == SRC_DATA);
    assign i_rdata   = i_data_ok ? s_rdata : '0;
    assign d_rdata   = d_data_ok ? s_rdata : '0;

    sram_bus_arbiter_src_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_src_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (grant),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset)
            err_stray <= 1'b0;
        else if (s_data_ok && fifo_empty)
            err_stray <= 1'b1;
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based model.
module tb_sram_bus_arbiter;

    localparam int OUT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [3:0]  i_wstrb, d_wstrb;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        err_stray;

    int vectors = 0;
    int miscompares = 0;

    sram_bus_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_wstrb(i_wstrb),
        .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .err_stray(err_stray)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of outstanding sources plus which master (if any) owns
    // a presented-but-unaccepted request (0 none, 1 I, 2 D).
    bit mq[$];
    int owner = 0;
    bit merr = 1'b0;
    bit mvalid = 1'b0;
    int n_owner;
    bit n_push, n_pushid, n_pop, n_err;
    bit m_full, m_g, m_sreq, m_acc, m_resp, m_hid;

    always @(negedge clk) begin
        if (mvalid) begin
            m_full = (mq.size() == OUT);
            if (owner == 0) begin
                m_g    = d_req;
                m_sreq = !m_full && (i_req || d_req);
            end else begin
                m_g    = (owner == 2);
                m_sreq = m_g ? d_req : i_req;
            end
            if (reset) m_sreq = 1'b0;
            m_acc  = m_sreq && s_addr_ok;
            m_resp = !reset && s_data_ok && (mq.size() > 0);
            m_hid  = m_resp ? mq[0] : 1'b0;

            chk("m_s_req", 32'(s_req), 32'(m_sreq));
            chk("m_i_addr_ok", 32'(i_addr_ok), 32'(m_acc && !m_g));
            chk("m_d_addr_ok", 32'(d_addr_ok), 32'(m_acc && m_g));
            chk("m_i_data_ok", 32'(i_data_ok), 32'(m_resp && !m_hid));
            chk("m_d_data_ok", 32'(d_data_ok), 32'(m_resp && m_hid));
            chk("m_i_rdata", i_rdata, (m_resp && !m_hid) ? s_rdata : 32'h0);
            chk("m_d_rdata", d_rdata, (m_resp && m_hid) ? s_rdata : 32'h0);
            chk("m_err_stray", 32'(err_stray), 32'(merr));
            if (m_sreq) begin
                chk("m_s_addr", s_addr, m_g ? d_addr : i_addr);
                chk("m_s_wdata", s_wdata, m_g ? d_wdata : i_wdata);
                chk("m_s_ctrl", {25'h0, s_wr, s_size, s_wstrb},
                    m_g ? {25'h0, d_wr, d_size, d_wstrb} : {25'h0, i_wr, i_size, i_wstrb});
            end

            n_push   = m_acc;
            n_pushid = m_g;
            n_pop    = m_resp;
            n_err    = merr | (!reset && s_data_ok && mq.size() == 0);
            n_owner  = owner;
            if (m_acc)                        n_owner = 0;
            else if (owner == 0 && m_sreq)    n_owner = m_g ? 2 : 1;
            else if (owner != 0 && !m_sreq)   n_owner = 0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            owner  = 0;
            merr   = 1'b0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            if (n_pop)  void'(mq.pop_front());
            if (n_push) mq.push_back(n_pushid);
            owner = n_owner;
            merr  = n_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        i_wr = 0; i_size = 2'd2; i_wstrb = 4'hf; i_addr = 32'h0; i_wdata = 32'h0;
        d_wr = 1; d_size = 2'd2; d_wstrb = 4'hf; d_addr = 32'h0; d_wdata = 32'h0;
        i_req = 1; d_req = 1; s_addr_ok = 1; s_data_ok = 1; s_rdata = 32'hdead_beef;

        // Reset gates all handshakes even with every request and ack active.
        @(negedge clk);
        chk("rst_s_req", 32'(s_req), 32'h0);
        chk("rst_addr_ok", {30'h0, i_addr_ok, d_addr_ok}, 32'h0);
        chk("rst_data_ok", {30'h0, i_data_ok, d_data_ok}, 32'h0);
        tick();
        do_reset();
        @(negedge clk);
        chk("rst_err_stray", 32'(err_stray), 32'h0);

        // Single I read, accepted at once, answered two cycles later.
        i_req = 1; i_addr = 32'h1c00_0000; s_addr_ok = 1;
        @(negedge clk);
        chk("t1_s_req", 32'(s_req), 32'h1);
        chk("t1_s_addr", s_addr, 32'h1c00_0000);
        chk("t1_i_addr_ok", 32'(i_addr_ok), 32'h1);
        chk("t1_d_addr_ok", 32'(d_addr_ok), 32'h0);
        tick();
        i_req = 0; s_addr_ok = 0;
        @(negedge clk);
        chk("t1_early_data_ok", 32'(i_data_ok), 32'h0);
        tick();
        s_data_ok = 1; s_rdata = 32'h02c0_0000;
        @(negedge clk);
        chk("t1_i_data_ok", 32'(i_data_ok), 32'h1);
        chk("t1_i_rdata", i_rdata, 32'h02c0_0000);
        chk("t1_d_silent", {d_rdata[30:0], d_data_ok}, 32'h0);
        tick();
        s_data_ok = 0;

        // Both request in the same IDLE cycle: D first, then I.
        i_req = 1; d_req = 1; i_addr = 32'h0000_1000; d_addr = 32'h0000_2000; s_addr_ok = 1;
        @(negedge clk);
        chk("t2_s_addr_d", s_addr, 32'h0000_2000);
        chk("t2_addr_ok_d", {30'h0, i_addr_ok, d_addr_ok}, 32'h1);
        tick();
        d_req = 0;
        @(negedge clk);
        chk("t2_s_addr_i", s_addr, 32'h0000_1000);
        chk("t2_addr_ok_i", {30'h0, i_addr_ok, d_addr_ok}, 32'h2);
        tick();
        do_reset();

        // I held three cycles; a later D request must wait for the I accept.
        i_req = 1; i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; s_addr_ok = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) d_req = 1;
            if (c == 3) s_addr_ok = 1;
            @(negedge clk);
            chk("t3_s_addr_held", s_addr, 32'h0000_0100);
            chk("t3_addr_ok", {30'h0, i_addr_ok, d_addr_ok}, (c == 3) ? 32'h2 : 32'h0);
            tick();
        end
        i_req = 0;
        @(negedge clk);
        chk("t3_s_addr_d", s_addr, 32'h0000_0200);
        chk("t3_d_addr_ok", 32'(d_addr_ok), 32'h1);
        tick();
        do_reset();

        // Fill all OUT slots; the next request is withheld until one response frees a slot.
        i_req = 1; s_addr_ok = 1;
        for (int c = 0; c < OUT; c++) begin
            @(negedge clk);
            chk("t4_fill_addr_ok", 32'(i_addr_ok), 32'h1);
            tick();
        end
        @(negedge clk);
        chk("t4_full_s_req", 32'(s_req), 32'h0);
        chk("t4_full_addr_ok", 32'(i_addr_ok), 32'h0);
        tick();
        s_data_ok = 1; s_rdata = 32'h5;
        @(negedge clk);
        chk("t4_pop_s_req", 32'(s_req), 32'h0);
        chk("t4_pop_data_ok", 32'(i_data_ok), 32'h1);
        tick();
        s_data_ok = 0;
        @(negedge clk);
        chk("t4_after_pop_addr_ok", 32'(i_addr_ok), 32'h1);
        tick();
        do_reset();

        // Accept I, D, I; responses must follow acceptance order.
        s_addr_ok = 1;
        i_req = 1; tick();
        i_req = 0; d_req = 1; tick();
        d_req = 0; i_req = 1; tick();
        i_req = 0; s_addr_ok = 0; s_data_ok = 1;
        s_rdata = 32'h11;
        @(negedge clk);
        chk("t5_r1", {i_rdata[29:0], i_data_ok, d_data_ok}, {32'h11, 2'b10} >> 0);
        tick();
        s_rdata = 32'h22;
        @(negedge clk);
        chk("t5_r2_d", d_rdata, 32'h22);
        chk("t5_r2_ok", {30'h0, i_data_ok, d_data_ok}, 32'h1);
        tick();
        s_rdata = 32'h33;
        @(negedge clk);
        chk("t5_r3_i", i_rdata, 32'h33);
        chk("t5_r3_ok", {30'h0, i_data_ok, d_data_ok}, 32'h2);
        tick();

        // Stray response with an empty FIFO: swallowed, sticky error until reset.
        s_rdata = 32'h44;
        @(negedge clk);
        chk("t6_stray_data_ok", {30'h0, i_data_ok, d_data_ok}, 32'h0);
        tick();
        s_data_ok = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_err_sticky", 32'(err_stray), 32'h1);
            tick();
        end
        do_reset();
        @(negedge clk);
        chk("t6_err_cleared", 32'(err_stray), 32'h0);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) i_req = ~i_req;
            if ($urandom_range(0, 3) == 0) d_req = ~d_req;
            if ($urandom_range(0, 2) == 0) begin
                i_addr = $urandom; i_wdata = $urandom; i_wr = $urandom_range(0, 1);
                i_size = 2'($urandom_range(0, 2)); i_wstrb = 4'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                d_addr = $urandom; d_wdata = $urandom; d_wr = $urandom_range(0, 1);
                d_size = 2'($urandom_range(0, 2)); d_wstrb = 4'($urandom);
            end
            s_addr_ok = $urandom_range(0, 1);
            s_data_ok = ($urandom_range(0, 2) == 0);
            s_rdata   = $urandom;
            tick();
        end

        reset = 0;
        idle_inputs();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
